// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM multi-client arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_CH   = 8;
    localparam int unsigned CH_IDX_W = $clog2(MAX_CH);

    // Bit offset of channel ch inside a bus packed as ch*width.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin / fixed-priority selector returning one-hot grant and index.
module rr_select
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]   i_req,
    input  logic [CH_IDX_W-1:0] i_ptr,
    input  logic                i_fixed,
    output logic [NUM_CH-1:0]   o_grant_c,
    output logic [CH_IDX_W-1:0] o_idx_c
);

    logic [CH_IDX_W-1:0] w_start;
    logic [NUM_CH-1:0]   w_rot;
    logic                w_found;
    int                  w_pos;

    assign w_start = i_fixed ? '0 : i_ptr;

    // Rotate so the search start sits at bit 0; lowest set bit then wins.
    assign w_rot = NUM_CH'({i_req, i_req} >> w_start);

    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_pos   = int'(w_start) + i;
            end
        end
        if (w_pos >= int'(NUM_CH)) begin
            w_pos = w_pos - int'(NUM_CH);
        end
        if (w_found) begin
            o_idx_c   = CH_IDX_W'(w_pos);
            o_grant_c = NUM_CH'(1) << w_pos;
        end
    end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// N-channel arbiter in front of the single-port SDRAM controller: one transfer
// at a time, per-channel read-data holding registers, recovery gap and timeout.
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ADDR_W  = 22,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     iCLK,
    input  logic                     iRST_n,
    input  logic                     iPRIO_MODE,
    input  logic [NUM_CH-1:0]        iCH_REQ,
    input  logic [NUM_CH-1:0]        iCH_WR,
    input  logic [NUM_CH*ADDR_W-1:0] iCH_ADDR,
    input  logic [NUM_CH*DATA_W-1:0] iCH_DATA,
    output logic [NUM_CH-1:0]        oCH_ACK,
    output logic [NUM_CH-1:0]        oCH_ERR,
    output logic [NUM_CH*DATA_W-1:0] oCH_DATA,
    output logic [NUM_CH-1:0]        oGRANT,
    output logic [ADDR_W-1:0]        oSDR_ADDR,
    output logic [DATA_W-1:0]        oSDR_DATA,
    output logic                     oSDR_RD,
    output logic                     oSDR_WR,
    input  logic [DATA_W-1:0]        iSDR_DATA,
    input  logic                     iSDR_Done
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W    = 4;
    localparam int unsigned TMO_LAST = TIMEOUT - 1;
    localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;

    arb_state_t          r_state;
    logic [CH_IDX_W-1:0] r_ptr;
    logic [CH_IDX_W-1:0] r_idx;
    logic [NUM_CH-1:0]   r_grant;
    logic [NUM_CH-1:0]   r_ack;
    logic [NUM_CH-1:0]   r_err;
    logic [ADDR_W-1:0]   r_sdr_addr;
    logic [DATA_W-1:0]   r_sdr_data;
    logic                r_rd;
    logic                r_wr;
    logic [TMO_W-1:0]    r_tmo;
    logic [GAP_W-1:0]    r_gap;
    logic [DATA_W-1:0]   r_ch_data [NUM_CH];

    logic [ADDR_W-1:0]   w_ch_addr  [NUM_CH];
    logic [DATA_W-1:0]   w_ch_wdata [NUM_CH];
    logic [NUM_CH-1:0]   w_sel_grant;
    logic [CH_IDX_W-1:0] w_sel_idx;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_win_wr;
    logic                w_tmo_hit;
    logic [CH_IDX_W-1:0] w_next_ptr;

    rr_select #(
        .NUM_CH (NUM_CH)
    ) u_rr_select (
        .i_req     (iCH_REQ),
        .i_ptr     (r_ptr),
        .i_fixed   (iPRIO_MODE),
        .o_grant_c (w_sel_grant),
        .o_idx_c   (w_sel_idx)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_ch_addr[c]  = iCH_ADDR[ch_lsb(c, ADDR_W) +: ADDR_W];
        assign w_ch_wdata[c] = iCH_DATA[ch_lsb(c, DATA_W) +: DATA_W];
        assign oCH_DATA[ch_lsb(c, DATA_W) +: DATA_W] = r_ch_data[c];
    end

    // One-hot AND-OR mux of the winning channel's request payload.
    always_comb begin
        w_win_addr = '0;
        w_win_data = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (w_sel_grant[c]) begin
                w_win_addr = w_win_addr | w_ch_addr[c];
                w_win_data = w_win_data | w_ch_wdata[c];
            end
        end
    end

    assign w_win_wr   = |(iCH_WR & w_sel_grant);
    assign w_tmo_hit  = (r_tmo == TMO_W'(TMO_LAST));
    assign w_next_ptr = (r_idx == CH_IDX_W'(NUM_CH - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_sdr_addr <= '0;
            r_sdr_data <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_tmo      <= '0;
            r_gap      <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                r_ch_data[c] <= '0;
            end
        end else begin
            r_ack <= '0;
            r_err <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|iCH_REQ) begin
                        r_grant    <= w_sel_grant;
                        r_idx      <= w_sel_idx;
                        r_sdr_addr <= w_win_addr;
                        r_sdr_data <= w_win_data;
                        r_wr       <= w_win_wr;
                        r_rd       <= !w_win_wr;
                        r_tmo      <= '0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Done takes precedence over a timeout landing on the same cycle.
                    if (iSDR_Done || w_tmo_hit) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_grant <= '0;
                        r_ack   <= r_grant;
                        r_err   <= iSDR_Done ? '0 : r_grant;
                        r_ptr   <= w_next_ptr;
                        r_gap   <= '0;
                        r_state <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                        if (iSDR_Done && r_rd) begin
                            for (int c = 0; c < int'(NUM_CH); c++) begin
                                if (r_grant[c]) begin
                                    r_ch_data[c] <= iSDR_DATA;
                                end
                            end
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_W'(GAP_LAST)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oCH_ACK   = r_ack;
    assign oCH_ERR   = r_err;
    assign oGRANT    = r_grant;
    assign oSDR_ADDR = r_sdr_addr;
    assign oSDR_DATA = r_sdr_data;
    assign oSDR_RD   = r_rd;
    assign oSDR_WR   = r_wr;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Bench for sdram_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_sdram_rr_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 22;
    localparam int DW  = 16;
    localparam int GAP = 2;
    localparam int TMO = 8;

    logic iCLK   = 1'b0;
    logic iRST_n = 1'b0;
    always #5 iCLK = ~iCLK;

    logic              prio = 1'b0;
    logic [NCH-1:0]    req  = '0;
    logic [NCH-1:0]    wr   = '0;
    logic [AW-1:0]     addr [NCH];
    logic [DW-1:0]     wdat [NCH];
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ack, err, grant;
    logic [NCH*DW-1:0] chd;
    logic [AW-1:0]     sdr_addr;
    logic [DW-1:0]     sdr_wdata;
    logic              rd_o, wr_o;
    logic [DW-1:0]     sdr_rdata = '0;
    logic              done      = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            ch_addr[c*AW +: AW]  = addr[c];
            ch_wdata[c*DW +: DW] = wdat[c];
        end
    end

    sdram_rr_arbiter #(
        .NUM_CH (NCH), .ADDR_W (AW), .DATA_W (DW), .GAP_CYC (GAP), .TIMEOUT (TMO)
    ) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iPRIO_MODE (prio),
        .iCH_REQ    (req),
        .iCH_WR     (wr),
        .iCH_ADDR   (ch_addr),
        .iCH_DATA   (ch_wdata),
        .oCH_ACK    (ack),
        .oCH_ERR    (err),
        .oCH_DATA   (chd),
        .oGRANT     (grant),
        .oSDR_ADDR  (sdr_addr),
        .oSDR_DATA  (sdr_wdata),
        .oSDR_RD    (rd_o),
        .oSDR_WR    (wr_o),
        .iSDR_DATA  (sdr_rdata),
        .iSDR_Done  (done)
    );

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    // Controller stand-in: Done on the lat-th strobe cycle (lat = 0 never answers).
    int   lat = 1, cyc = 0;
    bit   noise_en = 0, rand_lat = 0, fix_en = 0;
    logic [DW-1:0] fix_val = '0;
    always @(negedge iCLK) begin
        if (rd_o || wr_o) begin
            cyc++;
            if (cyc == 1 && rand_lat) lat = $urandom_range(1, 10);
        end else begin
            cyc = 0;
        end
        sdr_rdata = fix_en ? fix_val : DW'($urandom);
        done = (cyc != 0) ? (cyc == lat) : (noise_en && $urandom_range(0, 3) == 0);
    end

    // Reference model: who owns the SDRAM, how long it has waited, gap left.
    int            m_owner = -1, m_busy = 0, m_gap = 0, m_ptr = 0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_chd [NCH];
    logic [NCH-1:0] m_ack = '0, m_err = '0;

    always @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            m_owner = -1; m_busy = 0; m_gap = 0; m_ptr = 0;
            m_ack = '0; m_err = '0;
            for (int c = 0; c < NCH; c++) m_chd[c] = '0;
        end else begin
            m_ack = '0; m_err = '0;
            if (m_owner >= 0) begin
                m_busy++;
                if (done || m_busy == TMO) begin
                    m_ack[m_owner] = 1'b1;
                    if (!done) m_err[m_owner] = 1'b1;
                    else if (!m_wr) m_chd[m_owner] = sdr_rdata;
                    m_ptr   = (m_owner + 1) % NCH;
                    m_owner = -1;
                    m_gap   = GAP;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (req != 0) begin
                int start;
                start = prio ? 0 : m_ptr;
                for (int k = NCH - 1; k >= 0; k--) begin
                    if (req[(start + k) % NCH]) m_owner = (start + k) % NCH;
                end
                m_wr = wr[m_owner]; m_addr = addr[m_owner]; m_data = wdat[m_owner];
                m_busy = 0;
            end
        end
    end

    int          glog [$];
    logic [NCH-1:0] prev_grant = '0;

    // Per-cycle comparison of every output against the model.
    always @(posedge iCLK) begin
        logic [NCH-1:0]    e_grant;
        logic [NCH*DW-1:0] e_chd;
        #1;
        e_grant = (m_owner >= 0) ? (NCH'(1) << m_owner) : '0;
        for (int c = 0; c < NCH; c++) e_chd[c*DW +: DW] = m_chd[c];
        check("cyc_grant", 64'(grant), 64'(e_grant));
        check("cyc_rd", 64'(rd_o), 64'(m_owner >= 0 && !m_wr));
        check("cyc_wr", 64'(wr_o), 64'(m_owner >= 0 && m_wr));
        check("cyc_ack", 64'(ack), 64'(m_ack));
        check("cyc_err", 64'(err), 64'(m_err));
        check("cyc_chdata", 64'(chd), 64'(e_chd));
        if (m_owner >= 0) begin
            check("cyc_addr", 64'(sdr_addr), 64'(m_addr));
            if (m_wr) check("cyc_wdata", 64'(sdr_wdata), 64'(m_data));
        end
        if (grant != 0 && prev_grant == 0)
            for (int c = 0; c < NCH; c++) if (grant[c]) glog.push_back(c);
        prev_grant = grant;
    end

    // Randomized clients: hold until ACK, then drop or reissue.
    bit auto_en = 0, stop_new = 0;
    always @(posedge iCLK) begin
        if (auto_en) begin
            #2;
            for (int c = 0; c < NCH; c++) begin
                if (req[c]) begin
                    if (ack[c]) begin
                        if (stop_new || $urandom_range(0, 2) == 0) req[c] = 1'b0;
                        else begin
                            wr[c] = 1'($urandom); addr[c] = AW'($urandom); wdat[c] = DW'($urandom);
                        end
                    end else if (grant[c] && $urandom_range(0, 7) == 0) begin
                        req[c] = 1'b0;
                    end
                end else if (!stop_new && $urandom_range(0, 3) == 0) begin
                    wr[c] = 1'($urandom); addr[c] = AW'($urandom); wdat[c] = DW'($urandom);
                    req[c] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Waits for any ACK; nb counts strobe-high cycles seen before it.
    task automatic wait_ack(input int limit, output logic [NCH-1:0] a, output int nb);
        a = '0; nb = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (ack != 0) begin
                a = ack;
                return;
            end
            if (rd_o || wr_o) nb++;
        end
        n_tests++; n_fail++;
        $display("FAIL ack_wait @%0t: no ACK within %0d cycles", $time, limit);
    endtask

    task automatic do_reset();
        req = '0;
        iRST_n = 1'b0;
        tick();
        iRST_n = 1'b1;
        tick();
    endtask

    logic [NCH-1:0] a;
    int nb;

    initial begin
        for (int c = 0; c < NCH; c++) begin addr[c] = '0; wdat[c] = '0; end
        repeat (3) tick();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_strobe", 64'(rd_o | wr_o), 64'h0);
        check("rst_chdata", 64'(chd), 64'h0);
        iRST_n = 1'b1;
        tick();

        // Single read on ch2
        lat = 3; fix_en = 1; fix_val = 16'h5A5A;
        addr[2] = 22'h00ABC; wr[2] = 1'b0; req[2] = 1'b1;
        tick();
        check("rd_latency", 64'(rd_o), 64'h1);
        check("rd_addr", 64'(sdr_addr), 64'hABC);
        wait_ack(20, a, nb);
        check("rd_ack", 64'(a), 64'h4);
        check("rd_busy_rest", 64'(nb), 64'd2);
        check("rd_drop", 64'(rd_o), 64'h0);
        check("rd_err", 64'(err), 64'h0);
        check("rd_chdata2", 64'(chd[2*DW +: DW]), 64'h5A5A);
        req[2] = 1'b0; fix_en = 0;
        req[0] = 1'b1; wr[0] = 1'b0;
        tick();
        tick();
        check("gap_idle", 64'(rd_o), 64'h0);
        tick();
        check("gap_resume", 64'(grant), 64'h1);
        wait_ack(20, a, nb);
        check("gap_ack", 64'(a), 64'h1);
        req[0] = 1'b0;

        // Round-robin fairness
        do_reset();
        glog.delete();
        lat = 1; prio = 1'b0; wr = 4'b1010; req = 4'hF;
        for (int i = 0; i < 5; i++) wait_ack(20, a, nb);
        req = '0;
        check("rr_count", 64'(glog.size()), 64'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            check("rr_order", 64'(glog[i]), 64'(i % NCH));

        // Fixed priority, late ch0 request
        do_reset();
        glog.delete();
        prio = 1'b1; lat = 3; wr = '0; req = 4'b1010;
        wait_ack(20, a, nb);
        check("fp_first", 64'(a), 64'h2);
        req[1] = 1'b0;
        for (int i = 0; i < 10 && grant != 4'b1000; i++) tick();
        check("fp_ch3_busy", 64'(grant), 64'h8);
        req[0] = 1'b1;
        wait_ack(20, a, nb);
        check("fp_second", 64'(a), 64'h8);
        req[3] = 1'b0;
        wait_ack(20, a, nb);
        check("fp_third", 64'(a), 64'h1);
        req[0] = 1'b0;
        check("fp_log", 64'(glog.size() == 3 ? glog[2] : 99), 64'd0);
        prio = 1'b0;

        // Write path
        do_reset();
        lat = 4; wr[1] = 1'b1; wdat[1] = 16'h1234; addr[1] = 22'h3FFFFF; req[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_strobe", 64'(wr_o), 64'h1);
            check("wr_data", 64'(sdr_wdata), 64'h1234);
            check("wr_addr", 64'(sdr_addr), 64'h3FFFFF);
        end
        tick();
        check("wr_ack", 64'(ack), 64'h2);
        check("wr_chdata", 64'(chd), 64'h0);
        req[1] = 1'b0;

        // Timeout, then normal service, then Done on the last allowed cycle
        lat = 0; wr[0] = 1'b0; req[0] = 1'b1;
        wait_ack(30, a, nb);
        check("tmo_cycles", 64'(nb), 64'd8);
        check("tmo_ack", 64'(a), 64'h1);
        check("tmo_err", 64'(err), 64'h1);
        check("tmo_chdata", 64'(chd), 64'h0);
        req[0] = 1'b0;
        lat = 2; wr[3] = 1'b0; req[3] = 1'b1;
        wait_ack(30, a, nb);
        check("tmo_next_ack", 64'(a), 64'h8);
        check("tmo_next_err", 64'(err), 64'h0);
        req[3] = 1'b0;
        lat = 8; wr[1] = 1'b0; req[1] = 1'b1;
        wait_ack(30, a, nb);
        check("tmo_edge_cycles", 64'(nb), 64'd8);
        check("tmo_edge_ack", 64'(a), 64'h2);
        check("tmo_edge_err", 64'(err), 64'h0);
        req[1] = 1'b0;

        // Asynchronous reset in the middle of a read
        lat = 0; wr = '0; req = 4'b1010;
        repeat (4) tick();
        check("prerst_grant", 64'(grant), 64'h8);
        #2;
        iRST_n = 1'b0;
        #1;
        check("arst_rd", 64'(rd_o), 64'h0);
        check("arst_grant", 64'(grant), 64'h0);
        check("arst_ack", 64'(ack), 64'h0);
        check("arst_chdata", 64'(chd), 64'h0);
        tick();
        glog.delete();
        lat = 2;
        iRST_n = 1'b1;
        wait_ack(30, a, nb);
        check("arst_rearb", 64'(a), 64'h2);
        check("arst_first", 64'(glog.size() > 0 ? glog[0] : 99), 64'd1);
        req = '0;
        repeat (4) tick();

        // Randomized traffic
        noise_en = 1; rand_lat = 1; auto_en = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 49) == 0) prio = ~prio;
        end
        stop_new = 1;
        repeat (300) tick();
        auto_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_rr_arbiter.md
Name: sdram_rr_arbiter

Overview:
- Parametrised N-channel front end for the single-port SDRAM controller.
- Accepts independent read/write requests from NUM_CH clients over a req/ack handshake.
- Arbitrates round-robin or fixed-priority, and registers the winner's address, data and direction onto the controller port.
- Waits for iSDR_Done, returns per-channel latched read data, and enforces a recovery gap and a completion timeout.

Parameters:
- NUM_CH, 4: number of client channels (2..8).
- ADDR_W, 22: SDRAM word address width.
- DATA_W, 16: data width.
- GAP_CYC, 2: idle cycles between transfers (0..15).
- TIMEOUT, 1023: cycles to wait for iSDR_Done before aborting (1..65535).

Ports:
- iCLK  in  1  clock
- iRST_n  in  1  asynchronous, active-low reset
- iPRIO_MODE  in  1  0 = round-robin, 1 = fixed priority (ch0 highest); sampled only in IDLE
- iCH_REQ  in  NUM_CH  per-channel request level
- iCH_WR  in  NUM_CH  1 = write, 0 = read
- iCH_ADDR  in  NUM_CH*ADDR_W  channel c at bits [c*ADDR_W +: ADDR_W]
- iCH_DATA  in  NUM_CH*DATA_W  write data, same packing
- oCH_ACK  out  NUM_CH  one-cycle completion pulse
- oCH_ERR  out  NUM_CH  one-cycle pulse coincident with ACK when the transfer timed out
- oCH_DATA  out  NUM_CH*DATA_W  per-channel read-data holding registers
- oGRANT  out  NUM_CH  one-hot channel currently owning the SDRAM; 0 when idle
- oSDR_ADDR  out  ADDR_W  registered address to the controller
- oSDR_DATA  out  DATA_W  registered write data
- oSDR_RD  out  1  read strobe level
- oSDR_WR  out  1  write strobe level
- iSDR_DATA  in  DATA_W  controller read data
- iSDR_Done  in  1  controller completion

Behaviour:
- Reset: all outputs 0, including every oCH_DATA register; state IDLE; RR pointer 0; counters 0. Reset asserted mid-transfer drops RD/WR immediately; no ACK is issued.
- Handshake:
  - Client raises REQ with ADDR/DATA/WR stable and holds them until its ACK.
  - ACK is a single cycle.
  - REQ still high in the cycle after ACK counts as a new request.
  - REQ dropped before ACK does not cancel an issued transfer; it completes and is ACKed.
- States: IDLE, BUSY, GAP.
- IDLE, with any REQ:
  - Select the winner. Round-robin: first requesting channel at or after the pointer, wrapping modulo NUM_CH. Fixed priority: lowest index.
  - Next edge registers oGRANT, oSDR_ADDR, oSDR_DATA, and oSDR_WR = WR or oSDR_RD = !WR. Go to BUSY.
  - Latency from REQ to strobe: 1 cycle.
- BUSY:
  - Strobe, address and data are held constant.
  - Timeout counter increments every cycle.
  - On iSDR_Done (first cycle it is seen): drop strobe; for a read, latch iSDR_DATA into the winner's oCH_DATA; pulse oCH_ACK[winner]; RR pointer := winner+1 mod NUM_CH; go to GAP (or IDLE if GAP_CYC = 0).
  - Timeout: if the counter reaches TIMEOUT without Done, drop strobe, pulse ACK and ERR together, leave oCH_DATA unchanged, advance the pointer, go to GAP.
  - Done and timeout in the same cycle: Done wins, no ERR.
- GAP: count GAP_CYC cycles with strobes low and oGRANT = 0, then go to IDLE. Requests are not sampled during GAP.
- Ignored inputs: iSDR_Done while not BUSY. iPRIO_MODE changes outside IDLE take effect at the next arbitration.
- Fairness: with all channels requesting continuously in round-robin mode, grants rotate 0,1,..,NUM_CH-1.
- Registers: the oCH_DATA of non-winning channels never change.
- Throughput: 1 + Done latency + GAP_CYC cycles per transfer.

Decomposition:
- Package sdram_arb_pkg: state encoding (IDLE/BUSY/GAP), a clog2-based CH_IDX_W constant, and a function to slice packed channel buses.
- Sub-module rr_select: combinational, NUM_CH-wide. Takes req vector, pointer and mode; returns one-hot grant and index. It is reused by other multi-master blocks.
- The remainder (FSM, counters, data registers) stays in the top level.

Test Plan:
- Single read: ch2 REQ, WR=0, ADDR=0x00ABC; controller returns 0x5A5A with Done 3 cycles after RD. Required: RD high 1 cycle after REQ and low the cycle after Done; oCH_DATA[2] = 0x5A5A; ACK[2] for one cycle; 2-cycle gap.
- Round-robin: all 4 REQ held high with 1-cycle Done. Required: grant order 0,1,2,3,0; no channel is granted twice before every other requester has been granted once.
- Fixed priority: iPRIO_MODE = 1, REQ on ch3 and ch1 together. Required: ch1 served first, then ch3. Then ch0 REQ arrives during ch3's BUSY: ch0 is served after ch3's GAP.
- Write path: ch1 WR=1, DATA=0x1234, ADDR=0x3FFFFF. Required: oSDR_WR=1 with oSDR_DATA=0x1234 and oSDR_ADDR=0x3FFFFF stable until Done; oCH_DATA unchanged for all channels.
- Timeout: TIMEOUT = 8, Done never asserted. Required: strobe drops after 8 BUSY cycles; ACK and ERR pulse together; the next requester is then served normally. Variant with Done on exactly the 8th cycle: ACK only, no ERR.
- Reset mid-BUSY: iRST_n low during a read. Required: RD low asynchronously, no ACK, all oCH_DATA = 0; after release, a pending REQ is re-arbitrated from pointer 0.
